// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: architectural trap state, 64-bit
// cycle/instret counters, combinational read port with illegal-access detection.
module csr_file #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_wbk_v_i,
  input  logic [11:0]     csr_adr_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic            exception_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] mtval_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [1:0]      core_mode_i,
  input  logic            mret_i,
  input  logic            retire_i,
  input  logic [11:0]     csr_rd_adr_i,
  input  logic            csr_wr_intent_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            csr_illegal_o,
  output logic [XLEN-1:0] mepc_q_o,
  output logic [XLEN-1:0] mtvec_q_o,
  output logic            mie_bit_q_o
);

  logic            st_mie;
  logic            st_mpie;
  logic [1:0]      st_mpp;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [63:0]     mcycle_q;
  logic [63:0]     minstret_q;

  logic wr_en;
  logic rd_hit;

  // A trapping instruction is being flushed, so its CSR write never lands.
  assign wr_en = csr_wbk_v_i && !exception_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      st_mpp     <= 2'b11;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (exception_i) begin
        mepc_q   <= {mepc_i[XLEN-1:2], 2'b00};
        mcause_q <= mcause_i;
        mtval_q  <= mtval_i;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        st_mpp   <= core_mode_i;
      end else if (mret_i) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
        st_mpp  <= 2'b00;
      end else if (wr_en && csr_adr_i == 12'h300) begin
        st_mie  <= csr_data_i[3];
        st_mpie <= csr_data_i[7];
        if (csr_data_i[12:11] == 2'b00 || csr_data_i[12:11] == 2'b11)
          st_mpp <= csr_data_i[12:11];
      end

      if (wr_en) begin
        unique case (csr_adr_i)
          12'h304: mie_q      <= csr_data_i & 32'h0000_0888;
          12'h305: mtvec_q    <= {csr_data_i[XLEN-1:2], 2'b00};
          12'h340: mscratch_q <= csr_data_i;
          12'h341: mepc_q     <= {csr_data_i[XLEN-1:2], 2'b00};
          12'h342: mcause_q   <= csr_data_i;
          12'h343: mtval_q    <= csr_data_i;
          default: ;
        endcase
      end

      if (wr_en && csr_adr_i == 12'hB00)      mcycle_q[31:0]  <= csr_data_i;
      else if (wr_en && csr_adr_i == 12'hB80) mcycle_q[63:32] <= csr_data_i;
      else                                    mcycle_q        <= mcycle_q + 64'd1;

      if (wr_en && csr_adr_i == 12'hB02)      minstret_q[31:0]  <= csr_data_i;
      else if (wr_en && csr_adr_i == 12'hB82) minstret_q[63:32] <= csr_data_i;
      else if (retire_i && !exception_i)      minstret_q        <= minstret_q + 64'd1;
    end
  end

  always_comb begin
    csr_rd_data_o = '0;
    rd_hit        = 1'b1;
    unique case (csr_rd_adr_i)
      12'h300: csr_rd_data_o = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      12'h301: csr_rd_data_o = MISA_VAL;
      12'h304: csr_rd_data_o = mie_q;
      12'h305: csr_rd_data_o = mtvec_q;
      12'h340: csr_rd_data_o = mscratch_q;
      12'h341: csr_rd_data_o = mepc_q;
      12'h342: csr_rd_data_o = mcause_q;
      12'h343: csr_rd_data_o = mtval_q;
      12'h344: csr_rd_data_o = '0;
      12'hB00, 12'hC00: csr_rd_data_o = mcycle_q[31:0];
      12'hB80, 12'hC80: csr_rd_data_o = mcycle_q[63:32];
      12'hB02, 12'hC02: csr_rd_data_o = minstret_q[31:0];
      12'hB82, 12'hC82: csr_rd_data_o = minstret_q[63:32];
      12'hF14: csr_rd_data_o = '0;
      default: rd_hit = 1'b0;
    endcase
  end

  assign csr_illegal_o = !rd_hit || (csr_wr_intent_i && csr_rd_adr_i[11:10] == 2'b11);

  assign mepc_q_o    = mepc_q;
  assign mtvec_q_o   = mtvec_q;
  assign mie_bit_q_o = st_mie;

endmodule
